// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU 4:1 select path: channel codes used by both
// the mux and the demux, plus the holding-slot state encoding.
package cpu_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with EMPTY/FULL tracking for a demux channel.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   SLOT_EMPTY | no data held; output valid low
//   SLOT_FULL  | data held, presented until consumer takes it
module demux_slot
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load wins over a drain so that drain+fill in one cycle keeps the slot FULL.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_comb begin
        valid = (state_q == SLOT_FULL);
        data  = data_q;
    end

endmodule

// File: rtl/demux_4ch.sv
// Registered 1-to-4 valid/ready demultiplexer: steers one producer stream onto
// channels a/b/c/d by in_sel, each channel buffered by its own holding slot.
module demux_4ch
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*WIDTH-1:0]    out_data,
    output logic [NUM_CH-1:0]     out_valid,
    input  logic [NUM_CH-1:0]     out_ready,
    output logic [7:0]            xfer_cnt
);

    logic              accept;
    logic [NUM_CH-1:0] load_vec;
    logic [NUM_CH-1:0] slot_valid;
    logic [WIDTH-1:0]  slot_data [NUM_CH];
    logic [7:0]        xfer_cnt_q, xfer_cnt_d;

    // The only combinational path through the block: in_sel/out_ready -> in_ready.
    always_comb begin
        in_ready = ~slot_valid[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
        for (int k = 0; k < NUM_CH; k++) begin
            load_vec[k] = accept & (in_sel == 2'(k));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_vec[k]),
            .load_data (in_data),
            .drain     (out_ready[k]),
            .valid     (slot_valid[k]),
            .data      (slot_data[k])
        );
        assign out_data[k*WIDTH +: WIDTH] = slot_data[k];
    end

    assign out_valid = slot_valid;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (accept) begin
            xfer_cnt_d = xfer_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_demux_4ch.sv
// Self-checking bench for demux_4ch: per-channel expected-data queues filled by
// the stimulus, drained and compared by a monitor on every output handshake.
module tb_demux_4ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  xfer_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q [4][$];

    always #5 clk = ~clk;

    demux_4ch #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for a single cycle; exp_rdy is the hand-derived in_ready.
    task automatic offer(input logic [1:0] sel, input logic [7:0] data, input logic exp_rdy);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (exp_rdy) q[sel].push_back(data);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: every output handshake must match the channel's next expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (q[k].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out ch%0d: got %0h, expected no data", k, out_data[k*8 +: 8]);
                    end else begin
                        chk($sformatf("out_data ch%0d", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, q[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = 8'h00;
        out_ready = 4'b0000;
        repeat (3) cyc();
        chk("rst out_valid", {28'd0, out_valid}, 32'h0);
        chk("rst xfer_cnt", {24'd0, xfer_cnt}, 32'h0);
        chk("rst in_ready", {31'd0, in_ready}, 32'h1);
        chk("rst out_data", out_data, 32'h0);
        rst_n = 1'b1;
        cyc();

        // single routing to channel c
        offer(2'b10, 8'hA5, 1'b1);
        #1;
        chk("route out_valid", {28'd0, out_valid}, 32'h4);
        chk("route data c", {24'd0, out_data[23:16]}, 32'hA5);
        chk("route xfer_cnt", {24'd0, xfer_cnt}, 32'd1);
        out_ready = 4'b0100;
        cyc();
        chk("route drained", {28'd0, out_valid}, 32'h0);
        out_ready = 4'b0000;

        // back-pressure isolation
        offer(2'b11, 8'h11, 1'b1);
        offer(2'b00, 8'h22, 1'b1);
        offer(2'b00, 8'h33, 1'b0);
        chk("bp a held", {24'd0, out_data[7:0]}, 32'h22);
        offer(2'b10, 8'h55, 1'b1);
        out_ready = 4'b1000;
        offer(2'b11, 8'h44, 1'b1);
        chk("bp xfer_cnt", {24'd0, xfer_cnt}, 32'd5);
        chk("bp out_valid", {28'd0, out_valid}, 32'hD);
        out_ready = 4'b0001;
        cyc();
        chk("bp a drained", {28'd0, out_valid}, 32'hC);
        out_ready = 4'b1111;
        cyc();
        chk("bp all drained", {28'd0, out_valid}, 32'h0);
        out_ready = 4'b0000;

        // simultaneous drain and fill on channel d
        offer(2'b11, 8'h01, 1'b1);
        out_ready = 4'b1000;
        offer(2'b11, 8'h02, 1'b1);
        out_ready = 4'b0000;
        chk("dfill valid d", {31'd0, out_valid[3]}, 32'h1);
        chk("dfill data d", {24'd0, out_data[31:24]}, 32'h02);
        out_ready = 4'b1000;
        cyc();
        out_ready = 4'b0000;
        chk("dfill xfer_cnt", {24'd0, xfer_cnt}, 32'd7);

        // reset mid-stream with channel b full
        offer(2'b01, 8'hBB, 1'b1);
        chk("pre-rst b full", {28'd0, out_valid}, 32'h2);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) q[k].delete();
        #1;
        chk("midrst out_valid", {28'd0, out_valid}, 32'h0);
        chk("midrst xfer_cnt", {24'd0, xfer_cnt}, 32'h0);
        chk("midrst in_ready", {31'd0, in_ready}, 32'h1);
        cyc();
        rst_n = 1'b1;
        out_ready = 4'b1111;
        repeat (3) cyc();
        chk("postrst out_valid", {28'd0, out_valid}, 32'h0);

        // 256 back-to-back round-robin accepts, counter wraps to 0
        for (int i = 0; i < 256; i++) begin
            offer(2'(i), 8'(i * 7 + 3), 1'b1);
        end
        cyc();
        chk("stream xfer_cnt wrap", {24'd0, xfer_cnt}, 32'h0);
        chk("stream drained", {28'd0, out_valid}, 32'h0);

        // idle select changes
        out_ready = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            in_sel  = 2'(i);
            in_data = 8'(8'hC0 + i);
            cyc();
            chk("idle out_valid", {28'd0, out_valid}, 32'h0);
            chk("idle xfer_cnt", {24'd0, xfer_cnt}, 32'h0);
        end

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("queue ch%0d empty", k), q[k].size(), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
